// File: rtl/simon_iter_core.sv
// Iterative Simon block cipher core: one round per clock, external round-key
// store addressed through rk_idx, valid/ready handshakes on both sides.
module simon_iter_core #(
  parameter int N      = 64,
  parameter int ROUNDS = 68,
  parameter int CW     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_decrypt,
  input  logic [2*N-1:0]  in_block,
  output logic [CW-1:0]   rk_idx,
  input  logic [N-1:0]    rk_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*N-1:0]  out_block,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [CW-1:0]  cnt;
  logic           dec_q;
  logic [N-1:0]   x_q;
  logic [N-1:0]   y_q;
  logic [N-1:0]   x_nx;
  logic [N-1:0]   y_nx;
  logic           last_round;
  logic           accept;

  function automatic logic [N-1:0] rotl(input logic [N-1:0] v, input int unsigned r);
    return (v << r) | (v >> (N - r));
  endfunction

  function automatic logic [N-1:0] simon_f(input logic [N-1:0] v);
    return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
  endfunction

  assign last_round = (cnt == CW'(ROUNDS - 1));
  assign accept     = (state == IDLE) && in_valid;

  // State register: async reset, clear overrides everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     state <= IDLE;
    else if (clear) state <= IDLE;
    else            state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)   state_nx = RUN;
      RUN:     if (last_round) state_nx = DONE;
      DONE:    if (out_ready)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // One Simon round in the direction latched at accept.
  always_comb begin
    x_nx = x_q;
    y_nx = y_q;
    if (!dec_q) begin
      x_nx = y_q ^ simon_f(x_q) ^ rk_i;
      y_nx = x_q;
    end else begin
      x_nx = y_q;
      y_nx = x_q ^ simon_f(y_q) ^ rk_i;
    end
  end

  // Datapath: block load, round update, round counter and mode latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      y_q   <= '0;
      cnt   <= '0;
      dec_q <= 1'b0;
    end else if (clear) begin
      x_q   <= '0;
      y_q   <= '0;
      cnt   <= '0;
      dec_q <= 1'b0;
    end else if (accept) begin
      x_q   <= in_block[2*N-1:N];
      y_q   <= in_block[N-1:0];
      cnt   <= '0;
      dec_q <= in_decrypt;
    end else if (state == RUN) begin
      x_q <= x_nx;
      y_q <= y_nx;
      // Counter returns to zero after the last round so it never wraps past CW.
      cnt <= last_round ? '0 : cnt + CW'(1);
    end
  end

  // Outputs decoded from state; out_block comes straight from the registers.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    rk_idx    = '0;
    if (state == RUN)
      rk_idx = dec_q ? (CW'(ROUNDS - 1) - cnt) : cnt;
  end

  assign out_block = {x_q, y_q};

endmodule

// File: tb/tb_simon_iter_core.sv
// Bench for simon_iter_core: Simon32/64 and Simon128/128 instances, reference
// key schedule and cipher model, queue-based scoreboard of expected blocks.
module tb_simon_iter_core;

  localparam int R16 = 32;
  localparam int R64 = 68;

  logic clk;
  logic rst_n;

  logic         a_clear, a_in_valid, a_in_ready, a_in_decrypt;
  logic [31:0]  a_in_block, a_out_block;
  logic [4:0]   a_rk_idx;
  logic [15:0]  a_rk;
  logic         a_out_valid, a_out_ready, a_busy;

  logic         b_clear, b_in_valid, b_in_ready, b_in_decrypt;
  logic [127:0] b_in_block, b_out_block;
  logic [6:0]   b_rk_idx;
  logic [63:0]  b_rk;
  logic         b_out_valid, b_out_ready, b_busy;

  logic [63:0]  ks16 [0:R16-1];
  logic [63:0]  ks64 [0:R64-1];
  logic [127:0] q16 [$];
  logic [127:0] q64 [$];

  int total = 0;
  int bad   = 0;

  assign a_rk = ks16[a_rk_idx][15:0];
  assign b_rk = ks64[b_rk_idx];

  simon_iter_core #(.N(16), .ROUNDS(R16)) dut16 (
    .clk(clk), .rst_n(rst_n), .clear(a_clear),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_decrypt(a_in_decrypt),
    .in_block(a_in_block), .rk_idx(a_rk_idx), .rk_i(a_rk),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_block(a_out_block),
    .busy(a_busy)
  );

  simon_iter_core #(.N(64), .ROUNDS(R64)) dut64 (
    .clk(clk), .rst_n(rst_n), .clear(b_clear),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_decrypt(b_in_decrypt),
    .in_block(b_in_block), .rk_idx(b_rk_idx), .rk_i(b_rk),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_block(b_out_block),
    .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] msk(input int n);
    return (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
  endfunction

  function automatic logic [63:0] rol(input logic [63:0] v, input int r, input int n);
    logic [63:0] w;
    w = v & msk(n);
    return ((w << r) | (w >> (n - r))) & msk(n);
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] v, input int r, input int n);
    return rol(v, n - r, n);
  endfunction

  function automatic logic [63:0] ff(input logic [63:0] v, input int n);
    return (rol(v, 1, n) & rol(v, 8, n)) ^ rol(v, 2, n);
  endfunction

  // Standard Simon key schedule; z is written first-bit-first (MSB = z[0]).
  task automatic expand(input int s, input int n, input int m, input int rounds,
                        input logic [61:0] z, input logic [63:0] k0, input logic [63:0] k1,
                        input logic [63:0] k2, input logic [63:0] k3);
    logic [63:0] k [0:67];
    logic [63:0] tmp;
    k[0] = k0; k[1] = k1; k[2] = k2; k[3] = k3;
    for (int i = m; i < rounds; i++) begin
      tmp = ror(k[i-1], 3, n);
      if (m == 4) tmp = tmp ^ k[i-3];
      tmp = tmp ^ ror(tmp, 1, n);
      k[i] = ((~k[i-m]) & msk(n)) ^ tmp ^ {63'd0, z[61 - ((i - m) % 62)]} ^ 64'd3;
    end
    for (int i = 0; i < rounds; i++) begin
      if (s == 0) ks16[i] = k[i];
      else        ks64[i] = k[i];
    end
  endtask

  function automatic logic [127:0] model(input int s, input logic [127:0] blk, input logic dec);
    int n, rounds;
    logic [63:0] x, y, t, k;
    n      = (s == 0) ? 16 : 64;
    rounds = (s == 0) ? R16 : R64;
    x = 64'(blk >> n) & msk(n);
    y = blk[63:0] & msk(n);
    for (int i = 0; i < rounds; i++) begin
      if (!dec) begin
        k = (s == 0) ? ks16[i] : ks64[i];
        t = x; x = y ^ ff(x, n) ^ k; y = t;
      end else begin
        k = (s == 0) ? ks16[rounds-1-i] : ks64[rounds-1-i];
        t = y; y = x ^ ff(y, n) ^ k; x = t;
      end
    end
    return ({64'd0, x} << n) | {64'd0, y};
  endfunction

  // Drives one block into dut16 (called at a negedge with the core idle).
  task automatic run16(input logic [31:0] blk, input logic dec, input logic [31:0] expv, input int hold);
    int cycles;
    logic [127:0] got, e;
    q16.push_back(128'(expv));
    a_in_block = blk; a_in_decrypt = dec; a_in_valid = 1'b1;
    chk("ready16", 128'(a_in_ready), 128'(1));
    @(negedge clk);
    a_in_valid = 1'b0; a_in_block = $urandom; a_in_decrypt = ~dec;
    chk("busy16", 128'(a_busy), 128'(1));
    cycles = 0;
    while (!a_out_valid && cycles < R16 + 8) begin
      if (cycles < R16)
        chk("rkidx16", 128'(a_rk_idx), 128'(dec ? R16 - 1 - cycles : cycles));
      @(negedge clk);
      cycles++;
    end
    chk("lat16", 128'(cycles), 128'(R16));
    chk("rkidx_done16", 128'(a_rk_idx), 128'(0));
    got = 128'(a_out_block);
    e = q16.pop_front();
    chk("out16", got, e);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_blk16", 128'(a_out_block), got);
      chk("hold_rdy16", 128'(a_in_ready), 128'(0));
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    chk("ret_rdy16", 128'(a_in_ready), 128'(1));
    chk("ret_ov16", 128'(a_out_valid), 128'(0));
  endtask

  task automatic run64(input logic [127:0] blk, input logic dec, input logic [127:0] expv);
    int cycles;
    q64.push_back(expv);
    b_in_block = blk; b_in_decrypt = dec; b_in_valid = 1'b1;
    chk("ready64", 128'(b_in_ready), 128'(1));
    @(negedge clk);
    b_in_valid = 1'b0; b_in_block = {$urandom, $urandom, $urandom, $urandom}; b_in_decrypt = ~dec;
    cycles = 0;
    while (!b_out_valid && cycles < R64 + 8) begin
      @(negedge clk);
      cycles++;
    end
    chk("lat64", 128'(cycles), 128'(R64));
    chk("out64", b_out_block, q64.pop_front());
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    chk("ret_rdy64", 128'(b_in_ready), 128'(1));
  endtask

  initial begin
    logic [31:0]  p16, c16;
    logic [127:0] p64, c64;
    int seen;

    rst_n = 1'b0;
    a_clear = 1'b0; a_in_valid = 1'b0; a_in_decrypt = 1'b0; a_in_block = '0; a_out_ready = 1'b0;
    b_clear = 1'b0; b_in_valid = 1'b0; b_in_decrypt = 1'b0; b_in_block = '0; b_out_ready = 1'b0;

    expand(0, 16, 4, R16, 62'b11111010001001010110000111001101111101000100101011000011100110,
           64'h0100, 64'h0908, 64'h1110, 64'h1918);
    expand(1, 64, 2, R64, 62'b10101111011100000011010010011000101000010001111110010110110011,
           64'h0706050403020100, 64'h0f0e0d0c0b0a0908, 64'd0, 64'd0);

    repeat (3) @(negedge clk);
    chk("rst_rdy", 128'(a_in_ready), 128'(1));
    chk("rst_ov", 128'(a_out_valid), 128'(0));
    chk("rst_busy", 128'(a_busy), 128'(0));
    chk("rst_rkidx", 128'(a_rk_idx), 128'(0));
    chk("rst_blk", 128'(a_out_block), 128'(0));
    chk("rst_blk64", b_out_block, 128'(0));
    rst_n = 1'b1;

    // Known answers; first one is accepted on the first edge after reset.
    run16(32'h65656877, 1'b0, 32'hc69be9bb, 10);
    run16(32'hc69be9bb, 1'b1, 32'h65656877, 0);
    run64(128'h63736564207372656c6c657661727420, 1'b0, 128'h49681b1e1e54fe3f65aa832af84e0bbc);
    run64(128'h49681b1e1e54fe3f65aa832af84e0bbc, 1'b1, 128'h63736564207372656c6c657661727420);

    // Clear at round 5 discards the block.
    a_in_block = 32'h12345678; a_in_decrypt = 1'b0; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    repeat (5) @(negedge clk);
    a_clear = 1'b1;
    @(negedge clk);
    a_clear = 1'b0;
    chk("clr_rdy", 128'(a_in_ready), 128'(1));
    chk("clr_busy", 128'(a_busy), 128'(0));
    chk("clr_blk", 128'(a_out_block), 128'(0));
    seen = 0;
    for (int i = 0; i < R16 + 4; i++) begin
      @(negedge clk);
      if (a_out_valid) seen++;
    end
    chk("clr_noout", 128'(seen), 128'(0));
    run16(32'h65656877, 1'b0, 32'hc69be9bb, 0);

    // Asynchronous reset mid-RUN.
    a_in_block = 32'h0badf00d; a_in_decrypt = 1'b0; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_blk", 128'(a_out_block), 128'(0));
    chk("arst_busy", 128'(a_busy), 128'(0));
    chk("arst_rdy", 128'(a_in_ready), 128'(1));
    chk("arst_rkidx", 128'(a_rk_idx), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run16(32'hc69be9bb, 1'b1, 32'h65656877, 0);

    // Random round trips, ciphertext expectations from the reference model.
    for (int i = 0; i < 100; i++) begin
      p16 = $urandom;
      c16 = 32'(model(0, 128'(p16), 1'b0));
      run16(p16, 1'b0, c16, int'($urandom_range(0, 3)));
      run16(c16, 1'b1, p16, 0);
    end
    for (int i = 0; i < 30; i++) begin
      p64 = {$urandom, $urandom, $urandom, $urandom};
      c64 = model(1, p64, 1'b0);
      run64(p64, 1'b0, c64);
      run64(c64, 1'b1, p64);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
